gate_vector_checker: RTL

//   Self-checking stimulus/response stage around the basic gate cells (and1, or1, not1).

---
 rtl/gate_vector_checker.sv | 127 ++++++++++++
 1 files changed

// File: rtl/gate_vector_checker.sv
// Stimulus/response checker for the basic gate cells: steps {a,b} through 00,01,10,11,
// samples and1/or1/not1 after a settle time and reports mismatches in hardware.
module gate_vector_checker #(
  parameter int HOLD_CYCLES = 10,
  parameter int ERR_W       = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic             and_y,
  input  logic             or_y,
  input  logic             not_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       fail_vec,
  output logic [2:0]       fail_bits
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_DONE} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t     state, state_nx;
  logic [1:0] vec;
  logic [7:0] hold_cnt;
  logic       launch, sample, last;
  logic [2:0] mism;
  logic       err_sat;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next state and control strobes
  always_comb begin
    state_nx = state;
    launch   = 1'b0;
    sample   = 1'b0;
    last     = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nx = S_DRIVE;
          launch   = 1'b1;
        end
      end
      S_DRIVE: begin
        if (hold_cnt == HOLD_LAST) state_nx = S_SAMPLE;
      end
      S_SAMPLE: begin
        sample = 1'b1;
        if (vec == 2'd3) begin
          last     = 1'b1;
          state_nx = S_DONE;
        end else begin
          state_nx = S_DRIVE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Case-inequality so an X/Z gate output in simulation is counted as a mismatch
  always_comb begin
    mism    = 3'b000;
    mism[2] = (and_y !== (a & b));
    mism[1] = (or_y  !== (a | b));
    mism[0] = (not_y !== ~a);
  end

  assign err_sat = &err_count;
  assign busy    = (state == S_DRIVE) || (state == S_SAMPLE);

  // Datapath: operands, hold counter and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      vec       <= 2'd0;
      hold_cnt  <= 8'd0;
      a         <= 1'b0;
      b         <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_vec  <= 2'd0;
      fail_bits <= 3'd0;
    end else begin
      done <= last;
      if (launch) begin
        vec       <= 2'd0;
        hold_cnt  <= 8'd0;
        a         <= 1'b0;
        b         <= 1'b0;
        pass      <= 1'b0;
        err_count <= '0;
        fail_vec  <= 2'd0;
        fail_bits <= 3'd0;
      end else if (state == S_DRIVE) begin
        hold_cnt <= hold_cnt + 8'd1;
      end

      if (sample) begin
        if (mism != 3'b000) begin
          if (!err_sat) err_count <= err_count + ERR_W'(1);
          // err_count only returns to zero on a new run, so zero marks the first failure
          if (err_count == '0) begin
            fail_vec  <= vec;
            fail_bits <= mism;
          end
        end
        if (last) begin
          pass <= (err_count == '0) && (mism == 3'b000);
        end else begin
          vec      <= vec + 2'd1;
          hold_cnt <= 8'd0;
          {a, b}   <= vec + 2'd1;
        end
      end
    end
  end

endmodule
